instr_fetch_unit: RTL and testbench

Fetch stage that drives the instruction memory read port and presents fetched instructions to the decoder over a valid/ready handshake. It holds the program counter and absorbs the memory's one-cycle registered read latency in a 2-entry output buffer, so it can sustain one instruction per cycle under backpressure. It supports PC redirect for branches and jumps, and a level-sensitive halt.

---
 rtl/instr_fetch_unit.sv | 183 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to a memory with a
// one-cycle registered read latency, and buffers the returning words in a
// two-entry FIFO presented to the decoder over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 3,
  parameter int                    DATA_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_rd_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0]   pc_r;
  logic                    inflight_r;
  logic [ADDR_WIDTH-1:0]   inflight_pc_r;

  // FIFO storage: head entry drives the decoder outputs directly.
  logic [ADDR_WIDTH-1:0]   head_pc_r, tail_pc_r;
  logic [DATA_WIDTH-1:0]   head_data_r, tail_data_r;
  logic [1:0]              count_r;

  logic [ADDR_WIDTH-1:0]   head_pc_nxt_s, tail_pc_nxt_s;
  logic [DATA_WIDTH-1:0]   head_data_nxt_s, tail_data_nxt_s;
  logic [1:0]              count_nxt_s;

  logic                    pop_s;
  logic                    cap_s;
  logic                    issue_s;
  logic [2:0]              occ_s;

  assign instr_valid = (count_r != 2'd0);
  assign instr_data  = head_data_r;
  assign instr_pc    = head_pc_r;
  assign imem_addr   = pc_r;
  assign imem_rd_en  = issue_s;

  // Handshake, capture and issue decision; issue only when the returning
  // word is guaranteed a free slot after this cycle's pop.
  always_comb begin
    pop_s   = instr_valid & instr_ready;
    cap_s   = inflight_r & ~redirect_valid;
    occ_s   = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    issue_s = (state_r == ST_RUN) & ~redirect_valid & (occ_s < 3'd2);
  end

  // Next-state logic for the BOOT/RUN/HALTED controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_BOOT: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (halt) begin
          state_nxt_s = ST_HALTED;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (halt) begin
          state_nxt_s = ST_HALTED;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_BOOT;
      end
    endcase
  end

  // FIFO next contents: a redirect flushes; otherwise capture and pop are
  // both honoured, shifting the tail into the head on a pop.
  always_comb begin
    head_pc_nxt_s   = head_pc_r;
    head_data_nxt_s = head_data_r;
    tail_pc_nxt_s   = tail_pc_r;
    tail_data_nxt_s = tail_data_r;
    count_nxt_s     = count_r;
    if (redirect_valid) begin
      count_nxt_s = 2'd0;
    end else begin
      case ({cap_s, pop_s})
        2'b01: begin
          head_pc_nxt_s   = tail_pc_r;
          head_data_nxt_s = tail_data_r;
          count_nxt_s     = count_r - 2'd1;
        end
        2'b10: begin
          if (count_r == 2'd0) begin
            head_pc_nxt_s   = inflight_pc_r;
            head_data_nxt_s = imem_data;
          end else begin
            tail_pc_nxt_s   = inflight_pc_r;
            tail_data_nxt_s = imem_data;
          end
          count_nxt_s = count_r + 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head_pc_nxt_s   = inflight_pc_r;
            head_data_nxt_s = imem_data;
          end else begin
            head_pc_nxt_s   = tail_pc_r;
            head_data_nxt_s = tail_data_r;
            tail_pc_nxt_s   = inflight_pc_r;
            tail_data_nxt_s = imem_data;
          end
        end
        default: begin
          count_nxt_s = count_r;
        end
      endcase
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // PC and in-flight tracking; a redirect never coincides with an issue,
  // so the in-flight flag clears and the returning word is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      if (redirect_valid) begin
        pc_r <= redirect_pc;
      end else if (issue_s) begin
        pc_r <= pc_r + PC_ONE;
      end
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_pc_r <= pc_r;
      end
    end
  end

  // FIFO storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_pc_r   <= {ADDR_WIDTH{1'b0}};
      head_data_r <= {DATA_WIDTH{1'b0}};
      tail_pc_r   <= {ADDR_WIDTH{1'b0}};
      tail_data_r <= {DATA_WIDTH{1'b0}};
      count_r     <= 2'd0;
    end else begin
      head_pc_r   <= head_pc_nxt_s;
      head_data_r <= head_data_nxt_s;
      tail_pc_r   <= tail_pc_nxt_s;
      tail_data_r <= tail_data_nxt_s;
      count_r     <= count_nxt_s;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a registered-read memory model
// and a monitor that logs every accepted (pc, data) handshake.
module tb_instr_fetch_unit;
  localparam int AW = 3;
  localparam int DW = 10;

  logic          clk;
  logic          rst;
  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt;
  logic          instr_valid;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;

  logic [DW-1:0] mem [0:7];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_pc[$];
  int acc_data[$];
  int acc_cyc[$];

  instr_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(3'd0)) dut (
    .clk(clk), .rst(rst), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with one-cycle registered read, plus handshake logger.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_rd_en) imem_data <= mem[imem_addr];
    if (instr_valid && instr_ready && !rst) begin
      acc_pc.push_back(int'(instr_pc));
      acc_data.push_back(int'(instr_data));
      acc_cyc.push_back(cyc);
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1; redirect_valid = 1'b0; halt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acc_pc.delete(); acc_data.delete(); acc_cyc.delete();
  endtask

  task automatic wait_acc(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (acc_pc.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    instr_ready = 1'b0; rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0b expected 0", imem_rd_en); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", instr_valid); end
    checks++; if (instr_data !== 10'h000) begin errors++; $display("FAIL reset_data: got %0h expected 0", instr_data); end
    checks++; if (instr_pc !== 3'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", instr_pc); end
    checks++; if (imem_addr !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", imem_addr); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 3'd0) begin errors++; $display("FAIL first_issue: got rd_en=%0b addr=%0d expected 1/0", imem_rd_en, imem_addr); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL latency_c2: got valid=%0b expected 0", instr_valid); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 3'd0 || instr_data !== 10'h100) begin errors++; $display("FAIL latency_c3: got v=%0b pc=%0d d=%0h expected 1/0/100", instr_valid, instr_pc, instr_data); end
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL bp_c3_rd_en: got %0b expected 0", imem_rd_en); end
  endtask

  task automatic test_stream();
    bit ok;
    instr_ready = 1'b1;
    apply_reset();
    wait_acc(9, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stream_timeout: got %0d accepts expected 9", acc_pc.size()); end
    for (int i = 0; i < 9; i++) begin
      checks++; if (acc_pc[i] != i % 8 || acc_data[i] != 256 + i % 8) begin errors++; $display("FAIL stream_item%0d: got (%0d,%0h) expected (%0d,%0h)", i, acc_pc[i], acc_data[i], i % 8, 256 + i % 8); end
      checks++; if (acc_cyc[i] != acc_cyc[0] + i) begin errors++; $display("FAIL stream_bubble%0d: got cycle %0d expected %0d", i, acc_cyc[i], acc_cyc[0] + i); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int issues;
    instr_ready = 1'b0;
    apply_reset();
    issues = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_rd_en) issues++;
    end
    checks++; if (issues != 2) begin errors++; $display("FAIL bp_issues: got %0d expected 2", issues); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 3'd0) begin errors++; $display("FAIL bp_head: got v=%0b pc=%0d expected 1/0", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    #1;
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 3'd2) begin errors++; $display("FAIL bp_reassert: got rd_en=%0b addr=%0d expected 1/2", imem_rd_en, imem_addr); end
    wait_acc(5, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got %0d accepts expected 5", acc_pc.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (acc_pc[i] != i || acc_data[i] != 256 + i) begin errors++; $display("FAIL bp_item%0d: got (%0d,%0h) expected (%0d,%0h)", i, acc_pc[i], acc_data[i], i, 256 + i); end
    end
  endtask

  task automatic test_redirect_flush();
    bit ok;
    int exp_pc[6] = '{0, 1, 5, 6, 7, 0};
    instr_ready = 1'b1;
    apply_reset();
    repeat (5) @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 3'd2) begin errors++; $display("FAIL rf_pre: got v=%0b pc=%0d expected 1/2", instr_valid, instr_pc); end
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 3'd5;
    #1;
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL rf_no_issue: got %0b expected 0", imem_rd_en); end
    @(negedge clk);
    redirect_valid = 1'b0; instr_ready = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0 || imem_rd_en !== 1'b1 || imem_addr !== 3'd5) begin errors++; $display("FAIL rf_r1: got v=%0b rd=%0b addr=%0d expected 0/1/5", instr_valid, imem_rd_en, imem_addr); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rf_r2: got valid=%0b expected 0", instr_valid); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 3'd5 || instr_data !== 10'h105) begin errors++; $display("FAIL rf_r3: got v=%0b pc=%0d d=%0h expected 1/5/105", instr_valid, instr_pc, instr_data); end
    wait_acc(6, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rf_timeout: got %0d accepts expected 6", acc_pc.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (acc_pc[i] != exp_pc[i] || acc_data[i] != 256 + exp_pc[i]) begin errors++; $display("FAIL rf_item%0d: got (%0d,%0h) expected pc %0d", i, acc_pc[i], acc_data[i], exp_pc[i]); end
    end
  endtask

  task automatic test_redirect_pop();
    bit ok;
    int exp_pc[6] = '{0, 1, 2, 6, 7, 0};
    instr_ready = 1'b1;
    apply_reset();
    repeat (5) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 3'd6;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rp_empty: got valid=%0b expected 0", instr_valid); end
    wait_acc(6, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rp_timeout: got %0d accepts expected 6", acc_pc.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (acc_pc[i] != exp_pc[i] || acc_data[i] != 256 + exp_pc[i]) begin errors++; $display("FAIL rp_item%0d: got (%0d,%0h) expected pc %0d", i, acc_pc[i], acc_data[i], exp_pc[i]); end
    end
  endtask

  task automatic test_halt();
    bit ok;
    instr_ready = 1'b1;
    apply_reset();
    repeat (5) @(negedge clk);
    halt = 1'b1;
    #1;
    checks++; if (imem_rd_en !== 1'b1) begin errors++; $display("FAIL halt_h: got rd_en=%0b expected 1", imem_rd_en); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL halt_rd_en%0d: got %0b expected 0", i, imem_rd_en); end
    end
    @(negedge clk);
    halt = 1'b0;
    #1;
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL halt_release: got rd_en=%0b expected 0", imem_rd_en); end
    @(negedge clk);
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 3'd5) begin errors++; $display("FAIL halt_resume: got rd=%0b addr=%0d expected 1/5", imem_rd_en, imem_addr); end
    wait_acc(9, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL halt_timeout: got %0d accepts expected 9", acc_pc.size()); end
    for (int i = 0; i < 9; i++) begin
      checks++; if (acc_pc[i] != i % 8 || acc_data[i] != 256 + i % 8) begin errors++; $display("FAIL halt_item%0d: got (%0d,%0h) expected (%0d,%0h)", i, acc_pc[i], acc_data[i], i % 8, 256 + i % 8); end
    end
  endtask

  task automatic test_reset_midop();
    bit ok;
    instr_ready = 1'b0;
    apply_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0 || imem_rd_en !== 1'b0) begin errors++; $display("FAIL rm_boot: got v=%0b rd=%0b expected 0/0", instr_valid, imem_rd_en); end
    checks++; if (instr_data !== 10'h000 || instr_pc !== 3'd0) begin errors++; $display("FAIL rm_outs: got d=%0h pc=%0d expected 0/0", instr_data, instr_pc); end
    rst = 1'b0; instr_ready = 1'b1;
    acc_pc.delete(); acc_data.delete(); acc_cyc.delete();
    @(negedge clk);
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 3'd0) begin errors++; $display("FAIL rm_restart: got rd=%0b addr=%0d expected 1/0", imem_rd_en, imem_addr); end
    wait_acc(3, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_timeout: got %0d accepts expected 3", acc_pc.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (acc_pc[i] != i || acc_data[i] != 256 + i) begin errors++; $display("FAIL rm_item%0d: got (%0d,%0h) expected (%0d,%0h)", i, acc_pc[i], acc_data[i], i, 256 + i); end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 10'h100 + 10'(i);
    imem_data = 10'h000;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 3'd0; halt = 1'b0; instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_pop();
    test_halt();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
